// File: rtl/issue_queue_pkg.sv
// Shared widths and the issue bundle layout consumed by the execute stage.
package issue_queue_pkg;

  localparam int unsigned WORD_LEN    = 32;
  localparam int unsigned PC_LEN      = 32;
  localparam int unsigned TAG_LEN     = 4;
  localparam int unsigned OPSEL_LEN   = 2;
  localparam int unsigned ALUFUNC_LEN = 4;

  typedef struct packed {
    logic [OPSEL_LEN-1:0]   opsel1;
    logic [OPSEL_LEN-1:0]   opsel2;
    logic [ALUFUNC_LEN-1:0] alu_func;
    logic [WORD_LEN-1:0]    rs1;
    logic [WORD_LEN-1:0]    rs2;
    logic [WORD_LEN-1:0]    imm;
    logic [PC_LEN-1:0]      pc;
    logic [TAG_LEN-1:0]     dst_tag;
  } iss_bundle_t;

endpackage

// File: rtl/iq_entry_wakeup.sv
// One operand slot's compare/capture against the result broadcast bus.
module iq_entry_wakeup
  import issue_queue_pkg::*;
#(
  parameter int unsigned WORD    = 32,
  parameter int unsigned TAG_LEN = 4
) (
  input  logic               cdb_valid,
  input  logic [TAG_LEN-1:0] cdb_tag,
  input  logic [WORD-1:0]    cdb_value,
  input  logic               rdy,
  input  logic [TAG_LEN-1:0] tag,
  input  logic [WORD-1:0]    value,
  output logic               rdy_nxt_c,
  output logic [WORD-1:0]    value_nxt_c
);

  logic hit_c;

  // Only a still-pending operand may capture; ready operands keep their value.
  assign hit_c       = cdb_valid && !rdy && (tag == cdb_tag);
  assign rdy_nxt_c   = rdy | hit_c;
  assign value_nxt_c = hit_c ? cdb_value : value;

endmodule

// File: rtl/issue_queue.sv
// Age-ordered compacting reservation station: CDB wakeup, oldest-ready select, registered issue.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned WORD     = 32,
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned TAG_LEN  = 4,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [OPSEL_LEN-1:0]       disp_opsel1,
  input  logic [OPSEL_LEN-1:0]       disp_opsel2,
  input  logic [ALUFUNC_LEN-1:0]     disp_alu_func,
  input  logic [WORD-1:0]            disp_rs1_value,
  input  logic [WORD-1:0]            disp_rs2_value,
  input  logic [TAG_LEN-1:0]         disp_rs1_tag,
  input  logic [TAG_LEN-1:0]         disp_rs2_tag,
  input  logic                       disp_rs1_rdy,
  input  logic                       disp_rs2_rdy,
  input  logic [WORD-1:0]            disp_imm,
  input  logic [ADDR_LEN-1:0]        disp_pc,
  input  logic [TAG_LEN-1:0]         disp_dst_tag,
  input  logic                       cdb_valid,
  input  logic [TAG_LEN-1:0]         cdb_tag,
  input  logic [WORD-1:0]            cdb_value,
  output logic                       iss_valid,
  output logic [OPSEL_LEN-1:0]       iss_opsel1,
  output logic [OPSEL_LEN-1:0]       iss_opsel2,
  output logic [ALUFUNC_LEN-1:0]     iss_alu_func,
  output logic [WORD-1:0]            iss_rs1_value,
  output logic [WORD-1:0]            iss_rs2_value,
  output logic [WORD-1:0]            iss_imm,
  output logic [ADDR_LEN-1:0]        iss_pc,
  output logic [TAG_LEN-1:0]         iss_dst_tag,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [OPSEL_LEN-1:0]   opsel1;
    logic [OPSEL_LEN-1:0]   opsel2;
    logic [ALUFUNC_LEN-1:0] alu_func;
    logic [WORD-1:0]        rs1_value;
    logic [WORD-1:0]        rs2_value;
    logic [TAG_LEN-1:0]     rs1_tag;
    logic [TAG_LEN-1:0]     rs2_tag;
    logic                   rs1_rdy;
    logic                   rs2_rdy;
    logic [WORD-1:0]        imm;
    logic [ADDR_LEN-1:0]    pc;
    logic [TAG_LEN-1:0]     dst_tag;
  } entry_t;

  entry_t           ent_q    [DEPTH];
  entry_t           ent_woke [DEPTH];
  entry_t           ent_d    [DEPTH];
  entry_t           disp_ent;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] cnt_after;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             disp_accept;
  logic             byp1;
  logic             byp2;

  logic             woke_rs1_rdy [DEPTH];
  logic             woke_rs2_rdy [DEPTH];
  logic [WORD-1:0]  woke_rs1_val [DEPTH];
  logic [WORD-1:0]  woke_rs2_val [DEPTH];

  assign disp_ready  = (count_q < CNT_W'(DEPTH));
  assign disp_accept = disp_valid && disp_ready && !flush;
  assign occupancy   = count_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    iq_entry_wakeup #(.WORD(WORD), .TAG_LEN(TAG_LEN)) u_rs1 (
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_value  (cdb_value),
      .rdy        (ent_q[g].rs1_rdy),
      .tag        (ent_q[g].rs1_tag),
      .value      (ent_q[g].rs1_value),
      .rdy_nxt_c  (woke_rs1_rdy[g]),
      .value_nxt_c(woke_rs1_val[g])
    );
    iq_entry_wakeup #(.WORD(WORD), .TAG_LEN(TAG_LEN)) u_rs2 (
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_value  (cdb_value),
      .rdy        (ent_q[g].rs2_rdy),
      .tag        (ent_q[g].rs2_tag),
      .value      (ent_q[g].rs2_value),
      .rdy_nxt_c  (woke_rs2_rdy[g]),
      .value_nxt_c(woke_rs2_val[g])
    );
  end

  // Stored entries with this edge's CDB capture applied.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_woke[i]           = ent_q[i];
      ent_woke[i].rs1_rdy   = woke_rs1_rdy[i];
      ent_woke[i].rs1_value = woke_rs1_val[i];
      ent_woke[i].rs2_rdy   = woke_rs2_rdy[i];
      ent_woke[i].rs2_value = woke_rs2_val[i];
    end
  end

  // Incoming entry, with same-edge CDB bypass for pending operands.
  always_comb begin
    byp1                   = !disp_rs1_rdy && cdb_valid && (disp_rs1_tag == cdb_tag);
    byp2                   = !disp_rs2_rdy && cdb_valid && (disp_rs2_tag == cdb_tag);
    disp_ent.opsel1        = disp_opsel1;
    disp_ent.opsel2        = disp_opsel2;
    disp_ent.alu_func      = disp_alu_func;
    disp_ent.rs1_value     = byp1 ? cdb_value : disp_rs1_value;
    disp_ent.rs2_value     = byp2 ? cdb_value : disp_rs2_value;
    disp_ent.rs1_tag       = disp_rs1_tag;
    disp_ent.rs2_tag       = disp_rs2_tag;
    disp_ent.rs1_rdy       = disp_rs1_rdy | byp1;
    disp_ent.rs2_rdy       = disp_rs2_rdy | byp2;
    disp_ent.imm           = disp_imm;
    disp_ent.pc            = disp_pc;
    disp_ent.dst_tag       = disp_dst_tag;
  end

  // Oldest ready entry, from registered state only.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < count_q) && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Compaction: entries above the issued slot shift down; dispatch lands at the new tail.
  always_comb begin
    cnt_after = count_q - CNT_W'(sel_found);
    count_d   = cnt_after + CNT_W'(disp_accept);
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_woke[i];
      if (sel_found && (IDX_W'(i) >= sel_idx)) begin
        ent_d[i] = ent_woke[(i < DEPTH - 1) ? i + 1 : i];
      end
      if (disp_accept && (CNT_W'(i) == cnt_after)) begin
        ent_d[i] = disp_ent;
      end
    end
    if (flush) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  // Issue register: data holds when nothing issues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iss_valid     <= 1'b0;
      iss_opsel1    <= '0;
      iss_opsel2    <= '0;
      iss_alu_func  <= '0;
      iss_rs1_value <= '0;
      iss_rs2_value <= '0;
      iss_imm       <= '0;
      iss_pc        <= '0;
      iss_dst_tag   <= '0;
    end else if (flush) begin
      iss_valid <= 1'b0;
    end else begin
      iss_valid <= sel_found;
      if (sel_found) begin
        iss_opsel1    <= ent_q[sel_idx].opsel1;
        iss_opsel2    <= ent_q[sel_idx].opsel2;
        iss_alu_func  <= ent_q[sel_idx].alu_func;
        iss_rs1_value <= ent_q[sel_idx].rs1_value;
        iss_rs2_value <= ent_q[sel_idx].rs2_value;
        iss_imm       <= ent_q[sel_idx].imm;
        iss_pc        <= ent_q[sel_idx].pc;
        iss_dst_tag   <= ent_q[sel_idx].dst_tag;
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue with hand-computed expectations.
module tb_issue_queue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [1:0]  disp_opsel1;
  logic [1:0]  disp_opsel2;
  logic [3:0]  disp_alu_func;
  logic [31:0] disp_rs1_value;
  logic [31:0] disp_rs2_value;
  logic [3:0]  disp_rs1_tag;
  logic [3:0]  disp_rs2_tag;
  logic        disp_rs1_rdy;
  logic        disp_rs2_rdy;
  logic [31:0] disp_imm;
  logic [31:0] disp_pc;
  logic [3:0]  disp_dst_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        iss_valid;
  logic [1:0]  iss_opsel1;
  logic [1:0]  iss_opsel2;
  logic [3:0]  iss_alu_func;
  logic [31:0] iss_rs1_value;
  logic [31:0] iss_rs2_value;
  logic [31:0] iss_imm;
  logic [31:0] iss_pc;
  logic [3:0]  iss_dst_tag;
  logic [2:0]  occupancy;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  issue_queue dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .disp_valid    (disp_valid),
    .disp_ready    (disp_ready),
    .disp_opsel1   (disp_opsel1),
    .disp_opsel2   (disp_opsel2),
    .disp_alu_func (disp_alu_func),
    .disp_rs1_value(disp_rs1_value),
    .disp_rs2_value(disp_rs2_value),
    .disp_rs1_tag  (disp_rs1_tag),
    .disp_rs2_tag  (disp_rs2_tag),
    .disp_rs1_rdy  (disp_rs1_rdy),
    .disp_rs2_rdy  (disp_rs2_rdy),
    .disp_imm      (disp_imm),
    .disp_pc       (disp_pc),
    .disp_dst_tag  (disp_dst_tag),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_value     (cdb_value),
    .iss_valid     (iss_valid),
    .iss_opsel1    (iss_opsel1),
    .iss_opsel2    (iss_opsel2),
    .iss_alu_func  (iss_alu_func),
    .iss_rs1_value (iss_rs1_value),
    .iss_rs2_value (iss_rs2_value),
    .iss_imm       (iss_imm),
    .iss_pc        (iss_pc),
    .iss_dst_tag   (iss_dst_tag),
    .occupancy     (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    disp_valid     = 1'b0;
    disp_opsel1    = '0;
    disp_opsel2    = '0;
    disp_alu_func  = '0;
    disp_rs1_value = '0;
    disp_rs2_value = '0;
    disp_rs1_tag   = '0;
    disp_rs2_tag   = '0;
    disp_rs1_rdy   = 1'b0;
    disp_rs2_rdy   = 1'b0;
    disp_imm       = '0;
    disp_pc        = '0;
    disp_dst_tag   = '0;
    cdb_valid      = 1'b0;
    cdb_tag        = '0;
    cdb_value      = '0;
  endtask

  task automatic disp(input logic [31:0] v1, input logic r1, input logic [3:0] t1,
                      input logic [31:0] v2, input logic r2, input logic [3:0] t2,
                      input logic [31:0] pc, input logic [3:0] dst, input logic [3:0] func);
    disp_valid     = 1'b1;
    disp_opsel1    = 2'd1;
    disp_opsel2    = 2'd2;
    disp_alu_func  = func;
    disp_rs1_value = v1;
    disp_rs1_rdy   = r1;
    disp_rs1_tag   = t1;
    disp_rs2_value = v2;
    disp_rs2_rdy   = r2;
    disp_rs2_tag   = t2;
    disp_imm       = 32'h0000_0010;
    disp_pc        = pc;
    disp_dst_tag   = dst;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] v);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_value = v;
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_ready", 64'(disp_ready), 64'd1);
    chk("rst_rs1", 64'(iss_rs1_value), 64'd0);
    reset = 1'b1;

    // All-ready instruction: stored at edge 1, issued at edge 2.
    disp(32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 32'h100, 4'd3, 4'd0);
    tick();
    chk("t1_occ1", 64'(occupancy), 64'd1);
    chk("t1_nv", 64'(iss_valid), 64'd0);
    clr();
    tick();
    chk("t1_valid", 64'(iss_valid), 64'd1);
    chk("t1_rs1", 64'(iss_rs1_value), 64'd5);
    chk("t1_rs2", 64'(iss_rs2_value), 64'd7);
    chk("t1_pc", 64'(iss_pc), 64'h100);
    chk("t1_dst", 64'(iss_dst_tag), 64'd3);
    chk("t1_opsel1", 64'(iss_opsel1), 64'd1);
    chk("t1_imm", 64'(iss_imm), 64'h10);
    chk("t1_occ0", 64'(occupancy), 64'd0);
    tick();
    chk("t1_idle", 64'(iss_valid), 64'd0);

    // Younger ready instruction overtakes an older waiting one.
    disp(32'd0, 1'b0, 4'd2, 32'd1, 1'b1, 4'd0, 32'h200, 4'd4, 4'd1);
    tick();
    disp(32'd10, 1'b1, 4'd0, 32'd20, 1'b1, 4'd0, 32'h204, 4'd5, 4'd2);
    tick();
    chk("t2_occ2", 64'(occupancy), 64'd2);
    chk("t2_nv", 64'(iss_valid), 64'd0);
    clr();
    tick();
    chk("t2_b_valid", 64'(iss_valid), 64'd1);
    chk("t2_b_dst", 64'(iss_dst_tag), 64'd5);
    chk("t2_b_func", 64'(iss_alu_func), 64'd2);
    chk("t2_occ1", 64'(occupancy), 64'd1);
    cdb(4'd2, 32'hDEAD);
    tick();
    chk("t2_wake_nv", 64'(iss_valid), 64'd0);
    clr();
    tick();
    chk("t2_a_valid", 64'(iss_valid), 64'd1);
    chk("t2_a_rs1", 64'(iss_rs1_value), 64'hDEAD);
    chk("t2_a_dst", 64'(iss_dst_tag), 64'd4);
    chk("t2_a_pc", 64'(iss_pc), 64'h200);
    chk("t2_occ0", 64'(occupancy), 64'd0);

    // Dispatch-time CDB bypass.
    disp(32'd1, 1'b1, 4'd0, 32'd0, 1'b0, 4'd6, 32'h300, 4'd7, 4'd3);
    cdb(4'd6, 32'h42);
    tick();
    chk("t3_occ1", 64'(occupancy), 64'd1);
    chk("t3_nv", 64'(iss_valid), 64'd0);
    clr();
    tick();
    chk("t3_valid", 64'(iss_valid), 64'd1);
    chk("t3_rs2", 64'(iss_rs2_value), 64'h42);
    chk("t3_dst", 64'(iss_dst_tag), 64'd7);

    // Fill with four waiting entries (tags 8..11, dst 0..3).
    for (int k = 0; k < 4; k++) begin
      disp(32'd0, 1'b0, 4'(8 + k), 32'd0, 1'b1, 4'd0, 32'h400 + 32'(4 * k), 4'(k), 4'd0);
      tick();
    end
    chk("t4_occ4", 64'(occupancy), 64'd4);
    chk("t4_full", 64'(disp_ready), 64'd0);
    chk("t4_nv", 64'(iss_valid), 64'd0);
    disp(32'd0, 1'b0, 4'd12, 32'd0, 1'b1, 4'd0, 32'h500, 4'd15, 4'd0);
    tick();
    chk("t4_refused", 64'(occupancy), 64'd4);
    cdb(4'd10, 32'hA);
    tick();
    chk("t4_wake_occ", 64'(occupancy), 64'd4);
    chk("t4_wake_nv", 64'(iss_valid), 64'd0);
    cdb_valid = 1'b0;
    tick();
    chk("t4_iss_valid", 64'(iss_valid), 64'd1);
    chk("t4_iss_dst", 64'(iss_dst_tag), 64'd2);
    chk("t4_iss_rs1", 64'(iss_rs1_value), 64'hA);
    chk("t4_occ3", 64'(occupancy), 64'd3);
    chk("t4_ready", 64'(disp_ready), 64'd1);
    clr();
    cdb(4'd11, 32'hB);
    tick();
    chk("t4_b_nv", 64'(iss_valid), 64'd0);
    clr();
    tick();
    chk("t4_compact_dst", 64'(iss_dst_tag), 64'd3);
    chk("t4_compact_rs1", 64'(iss_rs1_value), 64'hB);
    chk("t4_compact_pc", 64'(iss_pc), 64'h40C);
    chk("t4_occ2", 64'(occupancy), 64'd2);

    // Flush with a ready entry pending.
    disp(32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 32'h600, 4'd12, 4'd0);
    tick();
    chk("t5_occ3", 64'(occupancy), 64'd3);
    clr();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_occ0", 64'(occupancy), 64'd0);
    chk("t5_nv", 64'(iss_valid), 64'd0);
    cdb(4'd8, 32'h77);
    tick();
    clr();
    tick();
    chk("t5_post_nv", 64'(iss_valid), 64'd0);
    chk("t5_post_occ", 64'(occupancy), 64'd0);

    // Async reset while an issue is visible.
    disp(32'h33, 1'b1, 4'd0, 32'h44, 1'b1, 4'd0, 32'h700, 4'd9, 4'd0);
    tick();
    clr();
    tick();
    chk("t6_pre_valid", 64'(iss_valid), 64'd1);
    chk("t6_pre_dst", 64'(iss_dst_tag), 64'd9);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_valid", 64'(iss_valid), 64'd0);
    chk("t6_async_occ", 64'(occupancy), 64'd0);
    chk("t6_async_dst", 64'(iss_dst_tag), 64'd0);
    #1;
    reset = 1'b1;
    tick();
    chk("t6_after_occ", 64'(occupancy), 64'd0);
    chk("t6_after_valid", 64'(iss_valid), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- In-order-aged reservation station that sits in front of the execute stage.
- Buffers dispatched ALU instructions whose source operands may still be pending.
- Captures pending operands from the result broadcast bus (CDB) by tag.
- Each cycle, issues the oldest fully-ready entry to execute as a registered bundle (opsel1/2, alu_func, rs1/rs2 values, imm, pc, destination tag).

Parameters:
- WORD, 32, data width of operands/imm/CDB value
- ADDR_LEN, 32, PC width
- TAG_LEN, 4, producer tag width
- DEPTH, 4, number of entries (power of 2, >=2)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- flush  in  1  synchronous squash of all entries and issue register
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept (comb: count < DEPTH)
- disp_opsel1, disp_opsel2  in  2 each  ALU mux selects, passed through
- disp_alu_func  in  4  ALU function, passed through
- disp_rs1_value, disp_rs2_value  in  WORD each  operand values (valid when rdy=1)
- disp_rs1_tag, disp_rs2_tag  in  TAG_LEN each  producer tags (used when rdy=0)
- disp_rs1_rdy, disp_rs2_rdy  in  1 each  operand already available
- disp_imm  in  WORD  immediate
- disp_pc  in  ADDR_LEN  instruction PC
- disp_dst_tag  in  TAG_LEN  tag this instruction will broadcast
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_LEN  broadcast tag
- cdb_value  in  WORD  broadcast value
- iss_valid  out  1  registered: bundle valid this cycle
- iss_opsel1, iss_opsel2, iss_alu_func, iss_rs1_value, iss_rs2_value, iss_imm, iss_pc, iss_dst_tag  out  matching widths  registered issue bundle
- occupancy  out  clog2(DEPTH+1)  live entry count

Behaviour:
- Reset (reset=0, async): all entry valid bits 0, occupancy 0, iss_valid 0, all iss_* data 0.
- Storage is a compacting array; index 0 is the oldest. Occupied entries are always 0..count-1.
- Dispatch is accepted on an edge with disp_valid && disp_ready && !flush. The entry is written at index count, or count-1 if an issue occurs on the same edge.
- disp_ready depends only on registered count; it does not credit a same-cycle issue. Full (count == DEPTH) means disp_ready = 0.
- Wakeup: on an edge with cdb_valid, every occupied operand with rdy=0 and tag == cdb_tag latches cdb_value and sets rdy=1. This also applies to entries shifting on that edge.
- Dispatch bypass: an incoming operand with rdy=0 whose tag matches a same-edge valid CDB is stored with rdy=1 and value = cdb_value.
- Select is combinational on registered state only: the lowest index with both rdy=1. There is no same-cycle CDB-to-select bypass.
- Issue: if a selected entry exists, on the edge the iss_* registers load its fields, iss_valid = 1, the entry is removed, and entries above it shift down by one. Otherwise iss_valid = 0 and the iss_* data hold their values.
- Execute never stalls; one issue per cycle maximum.
- Latency:
  - dispatch of an all-ready instruction at edge E gives iss_valid high after edge E+1;
  - a CDB wakeup at edge E makes the entry issuable, with iss_valid after edge E+1.
- Simultaneous dispatch + issue when full: dispatch is refused (disp_ready = 0); the issue proceeds.
- Empty queue: iss_valid = 0, occupancy = 0.
- flush: at the edge, all entries are invalidated, occupancy = 0 and iss_valid = 0. flush overrides both dispatch and issue on that edge.
- An async reset asserted mid-operation discards everything immediately.
- Tags are compared full-width. A CDB tag matching no entry is ignored.

Decomposition:
- Shared package: TAG_LEN, OPSEL_LEN = 2, ALUFUNC_LEN = 4, and an issue-bundle struct/typedef (opsel1, opsel2, alu_func, rs1, rs2, imm, pc, dst_tag) reused by execute.
- One natural sub-module: iq_entry_wakeup, a per-entry operand compare/capture against the CDB, instantiated 2×DEPTH.
- Select/compaction logic stays in the top level.

Test Plan:
- Reset release, dispatch rs1 = 5, rs2 = 7 both ready, func 0, pc 0x100, dst 3 at edge 1 -> iss_valid = 1 after edge 2 with rs1 = 5, rs2 = 7, pc 0x100, dst 3; occupancy 1 then 0.
- Dispatch A (rs1 waits tag 2), then B all-ready -> B issues first. A issues after CDB {tag 2, 0xDEAD} plus one edge, with iss_rs1_value = 0xDEAD.
- Dispatch with rs2 tag 6 not ready while CDB {6, 0x42} is valid on the same edge -> entry stored ready; issues next edge with rs2 = 0x42.
- Fill 4 non-ready entries -> disp_ready = 0, occupancy = 4, a fifth disp_valid is not accepted. Broadcast the tag of entry 2 -> entry 2 issues, entries compact, disp_ready = 1.
- With 3 entries, one ready, assert flush -> next cycle occupancy = 0, iss_valid = 0. A later CDB broadcast causes no issue.
- Async reset (reset = 0) asserted mid-cycle with iss_valid = 1 -> iss_valid and occupancy drop to 0 immediately, before the next clock edge.
